// File: rtl/cpu_pkg.sv
// Types and defaults shared by the memory port arbiter and its select unit.
package cpu_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned CntW     = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_e;

  typedef enum logic {
    OwnIf,
    OwnD
  } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Data-first winner selection with a saturating fetch-starvation counter.
module mem_arb_select
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   if_gnt_i,
  input  logic   d_gnt_i,
  output owner_e winner_o
);

  localparam int unsigned SW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  always_comb begin
    starved  = if_req_i && (starve_q == StarveMax);
    winner_o = (d_req_i && !starved) ? OwnD : OwnIf;
  end

  // Only data grants that overtake a waiting fetch count toward the limit.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_i) begin
      starve_d = '0;
    end else if (d_gnt_i && (starve_q != StarveMax)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters, one
// transaction at a time, returning read data with a single-cycle valid pulse.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q;
  owner_e            owner_q;
  owner_e            winner;
  logic [CntW-1:0]   cnt_q;
  logic              if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
  logic              mem_en_q, mem_we_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .clk_i    (clock),
    .rst_i    (reset),
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .if_gnt_i (if_gnt_q),
    .d_gnt_i  (d_gnt_q),
    .winner_o (winner)
  );

  // Strobes are set on entry to StIssue so they are high for exactly that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            state_q  <= StIssue;
            busy_q   <= 1'b1;
            owner_q  <= winner;
            mem_en_q <= 1'b1;
            if (winner == OwnD) begin
              d_gnt_q     <= 1'b1;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              if_gnt_q    <= 1'b1;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        StIssue: begin
          if (mem_we_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StWait;
            cnt_q   <= CntW'(MEM_LAT);
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (owner_q == OwnD) begin
              d_rdata_q  <= mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 16-bit memory port between the datapath's instruction-fetch requester and its load/store requester. Accepts one transaction at a time, drives the memory enable, write-enable, address and write-data lines, and returns read data with a one-cycle valid pulse. Arbitration is data-first with a starvation limit, so fetch always makes forward progress. It sits between the datapath's `mem_addr`/`mem_write_data`/`mem_read_*` signals and the unified memory.

## Interface

Parameters:
- `DATA_W`, 16: data width.
- `ADDR_W`, 16: address width.
- `MEM_LAT`, 2: cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range is 1..4.
- `STARVE_MAX`, 4: number of consecutive data grants allowed while `if_req` is pending.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request (read only).
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch issued to memory.
- `if_rvalid` out 1: `if_rdata` valid.
- `if_rdata` out DATA_W: fetch read data.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_gnt` out 1: data transaction issued.
- `d_rvalid` out 1: `d_rdata` valid.
- `d_rdata` out DATA_W: data read result.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: arbiter not in IDLE.

## Operation

- FSM states are IDLE, ISSUE and WAIT.
- **IDLE:** if any request is asserted, select a winner, latch owner, addr, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** drive `mem_en`=1, `mem_we`=latched we (0 for fetch), and the latched address and data. Pulse the owner's gnt for this cycle. A write goes to IDLE. A read loads counter=MEM_LAT and goes to WAIT.
- **WAIT:** decrement the counter each cycle. In the cycle it reaches 0, capture `mem_rdata` into the owner's rdata register and go to IDLE. The owner's rvalid pulses high for the following cycle.
- **Winner selection:** `d_req` beats `if_req`. The exception is when `starve_cnt` == STARVE_MAX and `if_req`=1, in which case fetch wins.
- **`starve_cnt`:** increments on each data grant while `if_req`=1. Clears on a fetch grant or whenever `if_req`=0. Saturates at STARVE_MAX.
- Requesters hold req, addr and data stable until gnt. The latched copy is used, so dropping req after selection does not cancel the transaction.
- Writes produce no rvalid. `d_gnt` is the write completion.
- rdata registers hold their value until the next read for the same owner.

## Timing

- **Reset values:** all outputs 0, state IDLE, `starve_cnt` 0, counter 0.
- **Read:** req seen in cycle T (IDLE); gnt and `mem_en` in T+1; `mem_rdata` sampled at the end of T+1+MEM_LAT; rvalid in T+2+MEM_LAT.
- The state is IDLE in the rvalid cycle, so a new selection there gives the next gnt at T+3+MEM_LAT. Read throughput is one read per MEM_LAT+2 cycles.
- **Write:** gnt and `mem_we` in T+1, IDLE in T+2, next gnt no earlier than T+3.
- `busy` is high in ISSUE and WAIT only.
- A new request is never accepted outside IDLE. At most one gnt and at most one rvalid are high in any cycle.
- **Simultaneous `if_req` and `d_req`:** data wins unless the starvation limit is reached. The loser stays pending with no gnt.
- **Reset asserted mid-WAIT:** the transaction is discarded and no rvalid is produced. All outputs are 0 asynchronously. After reset releases, the arbiter returns to IDLE.
- Counter width is 3 bits, which is sufficient for MEM_LAT ≤ 4.

## Structure

- **Shared package `cpu_pkg`:** state encoding (IDLE, ISSUE, WAIT), owner encoding (OWN_IF, OWN_D), and DATA_W/ADDR_W defaults.
- **Sub-module `mem_arb_select`:** priority decision plus `starve_cnt`. Inputs are `if_req`, `d_req` and grant events; output is the winner.
- The top level holds the FSM, latency counter, latch registers and rdata registers.

## Test plan

All scenarios use MEM_LAT=2 and a memory model returning `mem_rdata` 2 cycles after `mem_en`.

- **Reset:** assert `reset` for 10 ns → all outputs 0 and `busy`=0.
- **Single fetch:** `if_req`=1, `if_addr`=0x0004 in cycle 0, memory[0x0004]=0x41C2 → `if_gnt`, `mem_en` and `mem_addr`=0x0004 in cycle 1; `if_rvalid`=1 and `if_rdata`=0x41C2 in cycle 4 only.
- **Contention:** `if_req` and `d_req` (read 0x0010 = 0x000F) asserted together → `d_gnt` first, `d_rdata`=0x000F; `if_gnt` in the rvalid cycle + 1.
- **Write:** `d_req`, `d_we`=1, `d_addr`=0x0020, `d_wdata`=0x000F → `mem_we`=1 with that address and data for exactly one cycle with `d_gnt`; no `d_rvalid`; a read of 0x0020 afterwards returns 0x000F.
- **Starvation:** `d_req` read held high continuously and `if_req` held high → four `d_gnt`s, then `if_gnt` on the 5th grant, then data resumes.
- **Reset mid-WAIT:** assert reset one cycle after a read `d_gnt` → no `d_rvalid` ever appears for it; `busy`=0; the next request proceeds normally.
